// File: rtl/rv_pkg.sv
// rv_pkg: shared core constants and types, including the hex display peripheral map.
package rv_pkg;
  localparam logic [31:0] ADDRESS_PER = 32'h8000_0000;
  localparam logic [31:0] ADDRESS_HEX = 32'h8000_0004;
  localparam int HEX_CTRL_EN_BIT = 0;
  localparam int HEX_BLANK_LSB = 8;
  localparam int HEX_SCAN_DIV = 50000;
  typedef logic [6:0] seg7_t;
  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_e;
endpackage

// File: rtl/rv_hex7seg.sv
// rv_hex7seg: nibble to active-low gfedcba 7-segment pattern.
module rv_hex7seg
  import rv_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);
  always_comb begin
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      default: seg_o = 7'h0E;
    endcase
  end
endmodule

// File: rtl/rv_hex_periph.sv
// rv_hex_periph: bus slave with CTRL/HEX registers driving a scanned 8-digit 7-segment display.
module rv_hex_periph
  import rv_pkg::*;
#(
  parameter int SCAN_DIV = HEX_SCAN_DIV,
  parameter int DIGITS = 8
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              ack_o,
  output logic [31:0]       rdata_o,
  output logic [6:0]        hex_seg_o,
  output logic [DIGITS-1:0] hex_an_o
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DIGITS);
  bus_state_e state_q, state_d;
  logic en_q, en_d;
  logic [7:0] blank_q, blank_d;
  logic [31:0] hex_q, hex_d, rdata_q, rdata_d, ctrl_r;
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [DIGITS-1:0] an_q, an_d;
  seg7_t seg_q, seg_d, seg_dec;
  logic acc, sel_ctrl, sel_hex, wrap;
  rv_hex7seg u_dec (.nib_i(hex_q[{dig_q, 2'b00} +: 4]), .seg_o(seg_dec));
  always_comb begin
    acc = req_i && state_q == BUS_IDLE;
    state_d = acc ? BUS_ACK : BUS_IDLE;
    sel_ctrl = addr_i == ADDRESS_PER;
    sel_hex = addr_i == ADDRESS_HEX;
    ctrl_r = '0;
    ctrl_r[HEX_CTRL_EN_BIT] = en_q;
    ctrl_r[HEX_BLANK_LSB +: 8] = blank_q;
    // read data carries the pre-write value, so it is sampled from the current registers
    rdata_d = (acc && !we_i) ? (sel_ctrl ? ctrl_r : sel_hex ? hex_q : '0) : '0;
    en_d = en_q;
    blank_d = blank_q;
    hex_d = hex_q;
    if (acc && we_i && sel_ctrl) begin
      if (be_i[HEX_CTRL_EN_BIT / 8]) en_d = wdata_i[HEX_CTRL_EN_BIT];
      if (be_i[HEX_BLANK_LSB / 8]) blank_d = wdata_i[HEX_BLANK_LSB +: 8];
    end
    for (int i = 0; i < 4; i++)
      if (acc && we_i && sel_hex && be_i[i]) hex_d[8*i +: 8] = wdata_i[8*i +: 8];
    wrap = pre_q == PW'(SCAN_DIV - 1);
    pre_d = (en_q && !wrap) ? pre_q + PW'(1) : '0;
    dig_d = en_q ? dig_q + DW'(wrap) : '0;
    an_d = (en_q && !blank_q[dig_q]) ? ~(DIGITS'(1) << dig_q) : '1;
    seg_d = en_q ? seg_dec : 7'h7F;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BUS_IDLE;
      en_q <= 1'b0;
      blank_q <= '0;
      hex_q <= '0;
      rdata_q <= '0;
      pre_q <= '0;
      dig_q <= '0;
      an_q <= '1;
      seg_q <= 7'h7F;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      blank_q <= blank_d;
      hex_q <= hex_d;
      rdata_q <= rdata_d;
      pre_q <= pre_d;
      dig_q <= dig_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end
  assign ack_o = state_q == BUS_ACK;
  assign rdata_o = rdata_q;
  assign hex_an_o = an_q;
  assign hex_seg_o = seg_q;
endmodule
